rom_pixel_out: RTL and testbench
================================

// Module: rom_pixel_out
// PURPOSE
//  Downstream of the ROM-address scan generator. Registers the scan address to the image ROM and
//  captures the ROM colour word. Delays hs/vs/de by exactly the ROM read latency so sync and pixel
//  data stay aligned. Drives RGB888 plus sync to the 1080P video transmitter.
//  Also provides colour-bar and solid-colour test modes. Mode changes are applied only at frame start.
// PARAMETERS
//  ROM_LAT   2        ROM read latency in clocks, addr valid -> q valid (1..4)
//  H_ACTIVE  1920     active pixels per line (colour-bar width = H_ACTIVE/8)
//  SOLID_RGB 24'h0000FF  colour output in solid mode
// PORTS
//  clk       in   1   pixel clock (148.5 MHz for 1080P)
//  rst       in   1   synchronous reset, active-high
//  hs_in     in   1   line sync from scan generator, active-high
//  vs_in     in   1   frame sync from scan generator, active-high
//  de_in     in   1   data enable from scan generator
//  addr_in   in   17  ROM address from scan generator
//  mode      in   2   0=ROM image, 1=colour bars, 2=solid, 3=treated as 0
//  rom_addr  out  17  registered address to ROM
//  rom_q     in   24  ROM data, RGB888 {R,G,B}, valid ROM_LAT clocks after rom_addr
//  hs        out  1   delayed line sync
//  vs        out  1   delayed frame sync
//  de        out  1   delayed data enable
//  rgb       out  24  pixel colour {R[23:16],G[15:8],B[7:0]}
//  frame_cnt out  16  frames since reset, counts vs_in rising edges
// BEHAVIOUR
//  - Pipeline latency: fixed L = ROM_LAT+2 clocks from (hs_in,vs_in,de_in,addr_in) to (hs,vs,de,rgb).
//    Stage 0 registers rom_addr. Stages 1..ROM_LAT cover the ROM. The final stage registers rgb.
//  - hs/vs/de pass through an L-deep shift register. They are never altered except when forced low
//    in WAIT_VS (see FSM below).
//  - rgb = 24'h000000 whenever the delayed de is 0, in every mode.
//  - Mode 0: rgb = rom_q sampled at the final stage. Out-of-image pixels are black because the
//    upstream block already points them at the black ROM word.
//  - Mode 1 (colour bars):
//    - A bar counter counts pixels while the delayed de is high and clears when it is low.
//    - The bar index increments each H_ACTIVE/8 pixels and saturates at 7.
//    - Bar order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
//  - Mode 2: rgb = SOLID_RGB.
//  - mode is sampled only on a vs_in rising edge into mode_act. Changes mid-frame have no visible
//    effect until the next frame.
//  - FSM:
//    - WAIT_VS (reset state): hs, vs, de and rgb outputs held 0, pipeline still shifts.
//      Go to RUN on the first vs_in rising edge.
//    - RUN: normal output. Stay in RUN until rst.
//  - frame_cnt increments on each vs_in rising edge in either state and wraps FFFF -> 0000.
//  - Edge detect uses the registered previous vs_in. A vs_in high at reset release is not counted
//    as an edge.
//  - Reset (any time, including mid-line):
//    - On the next edge, all delay stages, rom_addr, hs, vs, de, rgb and frame_cnt become 0.
//    - mode_act becomes 0 and the state becomes WAIT_VS.
//  - No back-pressure: one pixel is accepted per clock, unconditionally.
// TESTING
//  1. ROM_LAT=2, ramp rom_q = addr model, de_in pulse with addr 100..103 -> de high 4 clks
//     later (L=4), rgb = model(100..103) aligned with de.
//  2. Reset, hold vs_in=0 for 1000 clks with de_in toggling -> hs/vs/de/rgb stay 0.
//     First vs_in rise -> outputs follow inputs 4 clks later.
//  3. mode=1 at frame start, full line of de -> pixels 0..239 FFFFFF, 240..479 FFFF00, ...,
//     1680..1919 000000. de low -> rgb 0.
//  4. Change mode 0->2 mid-frame -> ROM colours continue to frame end.
//     After next vs_in rise, active pixels = 0000FF.
//  5. Force frame_cnt to FFFF via 65535 vs pulses (or short frames) -> next vs_in rise gives 0000.
//  6. Assert rst for 1 clk mid-line with de high -> next clk all outputs 0, frame_cnt 0,
//     state WAIT_VS until the next vs_in rise.

Source files
------------

// File: rtl/rom_pixel_out.sv
// rom_pixel_out: registers the scan address to the image ROM, captures the ROM
// colour word and delays hs/vs/de by the ROM read latency so sync and pixel
// data leave aligned. Adds colour-bar and solid-colour test modes that switch
// only at frame start, and counts frames.
module rom_pixel_out #(
  parameter int          ROM_LAT   = 2,
  parameter int          H_ACTIVE  = 1920,
  parameter logic [23:0] SOLID_RGB = 24'h0000FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic [16:0] addr_in,
  input  logic [1:0]  mode,
  output logic [16:0] rom_addr,
  input  logic [23:0] rom_q,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [23:0] rgb,
  output logic [15:0] frame_cnt
);

  // L register stages: address, ROM_LAT inside the ROM, output colour.
  localparam int L      = ROM_LAT + 2;
  localparam int BAR_W  = H_ACTIVE / 8;
  localparam int BAR_CW = $clog2(BAR_W + 1);
  localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);

  typedef enum logic {WAIT_VS, RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_vs_prev;
  logic              w_vs_rise;
  logic              w_run_in;
  logic [1:0]        r_mode_act;
  logic [15:0]       r_frame_cnt;
  logic [16:0]       r_rom_addr_p0;
  logic [L-1:0]      r_hs_p;
  logic [L-1:0]      r_vs_p;
  logic [L-1:0]      r_de_p;
  logic              w_de_pre;
  logic [BAR_CW-1:0] r_bar_px;
  logic [2:0]        r_bar_idx;
  logic [23:0]       w_rgb_nxt;
  logic [23:0]       r_rgb_p;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // A vs_in already high when reset is released must not look like an edge,
  // so the previous-value register keeps tracking vs_in through reset.
  assign w_vs_rise = vs_in & ~r_vs_prev;

  // Previous vs_in for frame-start edge detection.
  always_ff @(posedge clk) begin
    r_vs_prev <= vs_in;
  end

  // State register: wait for the first frame start after reset.
  always_ff @(posedge clk) begin
    if (rst) r_state <= WAIT_VS;
    else     r_state <= w_state_nxt;
  end

  // Next state; w_run_in lets syncs into the pipeline from the first vs_in rise on.
  always_comb begin
    w_state_nxt = r_state;
    w_run_in    = 1'b0;
    case (r_state)
      WAIT_VS: begin
        if (w_vs_rise) begin
          w_state_nxt = RUN;
          w_run_in    = 1'b1;
        end
      end
      RUN:     w_run_in = 1'b1;
      default: w_state_nxt = WAIT_VS;
    endcase
  end

  // Mode latch and frame counter, both stepped only at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_act  <= 2'd0;
      r_frame_cnt <= 16'd0;
    end else if (w_vs_rise) begin
      r_mode_act  <= mode;
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Stage 0 address register and the L-deep sync delay line (gated while waiting).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_addr_p0 <= '0;
      r_hs_p        <= '0;
      r_vs_p        <= '0;
      r_de_p        <= '0;
    end else begin
      r_rom_addr_p0 <= addr_in;
      r_hs_p        <= {r_hs_p[L-2:0], hs_in & w_run_in};
      r_vs_p        <= {r_vs_p[L-2:0], vs_in & w_run_in};
      r_de_p        <= {r_de_p[L-2:0], de_in & w_run_in};
    end
  end

  // de as seen by the final stage, aligned with rom_q for the same pixel.
  assign w_de_pre = r_de_p[L-2];

  // Bar position: counts active pixels of the line, index saturates at the last bar.
  always_ff @(posedge clk) begin
    if (rst || !w_de_pre) begin
      r_bar_px  <= '0;
      r_bar_idx <= 3'd0;
    end else if (r_bar_px == BAR_LAST) begin
      r_bar_px  <= '0;
      if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_bar_px  <= r_bar_px + 1'b1;
    end
  end

  // Colour source select; blanked whenever the pixel is outside de.
  always_comb begin
    w_rgb_nxt = 24'h000000;
    if (w_de_pre) begin
      case (r_mode_act)
        2'd1:    w_rgb_nxt = bar_colour(r_bar_idx);
        2'd2:    w_rgb_nxt = SOLID_RGB;
        default: w_rgb_nxt = rom_q;
      endcase
    end
  end

  // Final stage colour register.
  always_ff @(posedge clk) begin
    if (rst) r_rgb_p <= 24'h000000;
    else     r_rgb_p <= w_rgb_nxt;
  end

  assign rom_addr  = r_rom_addr_p0;
  assign hs        = r_hs_p[L-1];
  assign vs        = r_vs_p[L-1];
  assign de        = r_de_p[L-1];
  assign rgb       = r_rgb_p;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_rom_pixel_out.sv
// Directed bench for rom_pixel_out: drives the scan inputs cycle by cycle and
// compares the delayed outputs with expected values queued per input cycle.
module tb_rom_pixel_out;

  localparam int ROM_LAT = 2;
  localparam int L       = ROM_LAT + 2;
  localparam int BAR_W   = 240;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hs_in = 1'b0, vs_in = 1'b0, de_in = 1'b0;
  logic [16:0] addr_in = '0;
  logic [1:0]  mode = 2'd0;
  logic [16:0] rom_addr;
  logic [23:0] rom_q;
  logic        hs, vs, de;
  logic [23:0] rgb;
  logic [15:0] frame_cnt;

  rom_pixel_out #(.ROM_LAT(ROM_LAT), .H_ACTIVE(1920), .SOLID_RGB(24'h0000FF)) dut (
    .clk(clk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .addr_in(addr_in), .mode(mode), .rom_addr(rom_addr), .rom_q(rom_q),
    .hs(hs), .vs(vs), .de(de), .rgb(rgb), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // ROM image: address ramp with a fixed tag in the red byte.
  function automatic logic [23:0] rom_model(input logic [16:0] a);
    return {7'd0, a} ^ 24'hC30000;
  endfunction

  logic [23:0] rq [ROM_LAT];
  always @(posedge clk) begin
    rq[0] <= rom_model(rom_addr);
    for (int i = 1; i < ROM_LAT; i++) rq[i] <= rq[i-1];
  end
  assign rom_q = rq[ROM_LAT-1];

  function automatic logic [23:0] bar_exp(input int px);
    int b;
    logic [23:0] tbl [8];
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    b = px / BAR_W;
    if (b > 7) b = 7;
    return tbl[b];
  endfunction

  typedef struct packed {
    logic        h;
    logic        v;
    logic        d;
    logic [23:0] c;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   running = 1'b0;
  logic vs_last = 1'b0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One input cycle; c is the colour the pixel must show if it is active.
  task automatic drv(input logic h, input logic v, input logic d,
                     input logic [16:0] a, input logic [23:0] c);
    bit   run;
    exp_t e;
    run = running || (v && !vs_last);
    if (run) running = 1'b1;
    vs_last = v;
    hs_in = h; vs_in = v; de_in = d; addr_in = a;
    e.h = h & run;
    e.v = v & run;
    e.d = d & run;
    e.c = (d & run) ? c : 24'h000000;
    q.push_back(e);
    tick;
    check_vec("rom_addr", {15'd0, rom_addr}, {15'd0, a});
    if (q.size() >= L) begin
      e = q.pop_front();
      check_vec("hs",  {31'd0, hs}, {31'd0, e.h});
      check_vec("vs",  {31'd0, vs}, {31'd0, e.v});
      check_vec("de",  {31'd0, de}, {31'd0, e.d});
      check_vec("rgb", {8'd0, rgb}, {8'd0, e.c});
    end
  endtask

  task automatic do_reset(input logic v);
    exp_t z;
    rst = 1'b1; vs_in = v; hs_in = 1'b1; de_in = 1'b1; addr_in = 17'h1ABCD;
    tick;
    check_vec("rst_hs",   {31'd0, hs}, 32'd0);
    check_vec("rst_vs",   {31'd0, vs}, 32'd0);
    check_vec("rst_de",   {31'd0, de}, 32'd0);
    check_vec("rst_rgb",  {8'd0, rgb}, 32'd0);
    check_vec("rst_addr", {15'd0, rom_addr}, 32'd0);
    check_vec("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
    rst = 1'b0;
    running = 1'b0;
    vs_last = v;
    q.delete();
    z = '0;
    for (int i = 0; i < L - 1; i++) q.push_back(z);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 17'd0, 24'h0);
  endtask

  task automatic vs_pulse;
    drv(1'b0, 1'b1, 1'b0, 17'd0, 24'h0);
    drv(1'b0, 1'b1, 1'b0, 17'd0, 24'h0);
    idle(3);
  endtask

  task automatic rom_line(input int base, input int n);
    drv(1'b1, 1'b0, 1'b0, 17'd0, 24'h0);
    idle(2);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b1, 17'(base + i), rom_model(17'(base + i)));
    idle(2);
  endtask

  task automatic bar_line(input int n);
    drv(1'b1, 1'b0, 1'b0, 17'd0, 24'h0);
    idle(2);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b1, 17'(i), bar_exp(i));
    idle(4);
  endtask

  task automatic solid_line(input int n);
    drv(1'b1, 1'b0, 1'b0, 17'd0, 24'h0);
    idle(2);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b1, 17'(500 + i), 24'h0000FF);
    idle(2);
  endtask

  initial begin
    do_reset(1'b0);

    // No frame start yet: outputs stay quiet while the address still flows.
    for (int i = 0; i < 1000; i++)
      drv((i % 5) == 0, 1'b0, i[0], 17'(i), 24'hFFFFFF);
    check_vec("fcnt_wait", {16'd0, frame_cnt}, 32'd0);

    // First frame, ROM image.
    mode = 2'd0;
    vs_pulse;
    check_vec("fcnt_f1", {16'd0, frame_cnt}, 32'd1);
    rom_line(100, 4);

    // Colour bars, including pixels past the last bar and a fresh short line.
    mode = 2'd1;
    vs_pulse;
    check_vec("fcnt_f2", {16'd0, frame_cnt}, 32'd2);
    bar_line(1930);
    bar_line(300);

    // Mode change mid-frame takes effect only at the next frame.
    mode = 2'd0;
    vs_pulse;
    rom_line(200, 5);
    mode = 2'd2;
    rom_line(205, 5);
    vs_pulse;
    solid_line(10);
    mode = 2'd3;
    vs_pulse;
    rom_line(50, 6);
    check_vec("fcnt_f5", {16'd0, frame_cnt}, 32'd5);

    // Frame counter wrap.
    force dut.r_frame_cnt = 16'hFFFE;
    idle(1);
    release dut.r_frame_cnt;
    idle(1);
    check_vec("fcnt_pre", {16'd0, frame_cnt}, 32'h0000FFFE);
    vs_pulse;
    check_vec("fcnt_ffff", {16'd0, frame_cnt}, 32'h0000FFFF);
    vs_pulse;
    check_vec("fcnt_wrap", {16'd0, frame_cnt}, 32'h00000000);

    // Reset mid-line with de high and vs_in held high across release.
    drv(1'b1, 1'b0, 1'b0, 17'd0, 24'h0);
    for (int i = 0; i < 6; i++) drv(1'b0, 1'b0, 1'b1, 17'(300 + i), rom_model(17'(300 + i)));
    do_reset(1'b1);
    drv(1'b0, 1'b1, 1'b1, 17'd7, 24'hFFFFFF);
    drv(1'b0, 1'b1, 1'b1, 17'd8, 24'hFFFFFF);
    check_vec("fcnt_vs_held", {16'd0, frame_cnt}, 32'd0);
    for (int i = 0; i < 20; i++) drv(i[1], 1'b0, i[0], 17'(i), 24'hFFFFFF);
    mode = 2'd2;
    vs_pulse;
    check_vec("fcnt_after_rst", {16'd0, frame_cnt}, 32'd1);
    solid_line(8);
    idle(L);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
